// File: rtl/lsq_unit.sv
// Load/store queue: in-order allocate at dispatch, in-order retire at commit,
// committed stores drained to the data cache over a valid/ready handshake.
package lsq_pkg;
  localparam logic [1:0] CAT_LOAD  = 2'd1;
  localparam logic [1:0] CAT_STORE = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [1:0]  category;
    logic [31:0] color;
    logic [31:0] address;
    logic [31:0] value;
    logic        ready;
  } lsq_entry;

  // All-ones tag and zero category keep a free slot from matching anything downstream.
  localparam lsq_entry LSQ_FREE = '{valid: 1'b0, tag: 32'hFFFF_FFFF, category: 2'd0,
                                    color: 32'd0, address: 32'd0, value: 32'd0, ready: 1'b0};
endpackage

module lsq_slot
  import lsq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        free,
  input  logic        alloc_we,
  input  logic [31:0] alloc_tag,
  input  logic [1:0]  alloc_cat,
  input  logic [31:0] alloc_color,
  input  logic        upd_we,
  input  logic [31:0] upd_addr,
  input  logic [31:0] upd_value,
  input  logic        upd_ready,
  input  logic        fill_we,
  input  logic [31:0] fill_data,
  output lsq_entry    entry
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        entry <= LSQ_FREE;
    else if (free)     entry <= LSQ_FREE;
    else if (alloc_we) entry <= '{valid: 1'b1, tag: alloc_tag, category: alloc_cat,
                                  color: alloc_color, address: 32'd0, value: 32'd0, ready: 1'b0};
    else if (entry.valid) begin
      if (upd_we) begin
        entry.address <= upd_addr;
        entry.value   <= upd_value;
        entry.ready   <= upd_ready;
      end
      // Fill is applied last so it wins value/ready over a same-cycle update.
      if (fill_we) begin
        entry.value <= fill_data;
        entry.ready <= 1'b1;
      end
    end
  end
endmodule

module lsq_unit
  import lsq_pkg::*;
#(
  parameter int LSQ_SIZE = 16,
  parameter int PTR_W    = $clog2(LSQ_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic [1:0]           alloc_category,
  input  logic [31:0]          alloc_tag,
  output logic                 alloc_ready,
  input  logic [31:0]          upd_pointer,
  input  lsq_entry             upd_entry,
  input  logic                 fill_valid,
  input  logic [PTR_W-1:0]     fill_index,
  input  logic [31:0]          fill_data,
  input  logic                 commit_valid,
  input  logic [31:0]          commit_tag,
  output logic                 commit_done,
  input  logic                 flush,
  output logic                 mem_wr_valid,
  output logic [31:0]          mem_wr_addr,
  output logic [31:0]          mem_wr_data,
  input  logic                 mem_wr_ready,
  output lsq_entry [LSQ_SIZE-1:0] lsq,
  output logic [31:0]          lsq_head,
  output logic [31:0]          lsq_tail
);
  typedef enum logic {IDLE, STORE_WR} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [31:0]      color_ctr;
  lsq_entry         head_e;
  logic             head_hit, retire, wr_start, alloc_go;
  logic             unused_bits;

  assign head_e      = lsq[head];
  assign head_hit    = commit_valid && head_e.valid && (head_e.tag == commit_tag) && head_e.ready;
  assign alloc_ready = (count != (PTR_W+1)'(LSQ_SIZE));
  assign alloc_go    = alloc_valid && alloc_ready && !flush;
  assign lsq_head    = 32'(head);
  assign lsq_tail    = 32'(tail);
  assign unused_bits = ^{upd_entry.valid, upd_entry.tag, upd_entry.category, upd_entry.color,
                         head_e.color};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A flush in IDLE takes priority over starting a commit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!flush && head_hit && head_e.category == CAT_STORE) state_nxt = STORE_WR;
      STORE_WR: if (mem_wr_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    retire   = 1'b0;
    wr_start = 1'b0;
    case (state)
      IDLE: if (!flush && head_hit) begin
        retire   = (head_e.category == CAT_LOAD);
        wr_start = (head_e.category == CAT_STORE);
      end
      STORE_WR: retire = mem_wr_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      color_ctr <= '0;
    end else begin
      head <= head + PTR_W'(retire);
      if (alloc_go) color_ctr <= color_ctr + 32'd1;
      if (flush) begin
        // An in-flight store survives the flush and retires on its own.
        if (state == STORE_WR) begin
          tail  <= head + PTR_W'(1);
          count <= retire ? '0 : (PTR_W+1)'(1);
        end else begin
          tail  <= head;
          count <= '0;
        end
      end else begin
        if (alloc_go) tail <= tail + PTR_W'(1);
        count <= count + (PTR_W+1)'(alloc_go) - (PTR_W+1)'(retire);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_done  <= 1'b0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
    end else begin
      commit_done <= retire;
      if (wr_start) begin
        mem_wr_valid <= 1'b1;
        mem_wr_addr  <= head_e.address;
        mem_wr_data  <= head_e.value;
      end else if (state == STORE_WR && mem_wr_ready) begin
        mem_wr_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LSQ_SIZE; i++) begin : g_slot
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic slot_free;
    assign slot_free = (retire && head == IDX) ||
                       (flush && !(state == STORE_WR && head == IDX));
    lsq_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .free       (slot_free),
      .alloc_we   (alloc_go && tail == IDX),
      .alloc_tag  (alloc_tag),
      .alloc_cat  (alloc_category),
      .alloc_color(color_ctr),
      .upd_we     (!flush && upd_pointer == 32'(i + 1)),
      .upd_addr   (upd_entry.address),
      .upd_value  (upd_entry.value),
      .upd_ready  (upd_entry.ready),
      .fill_we    (!flush && fill_valid && fill_index == IDX),
      .fill_data  (fill_data),
      .entry      (lsq[i])
    );
  end
endmodule
